// File: rtl/imm_instr_encoder_pkg.sv
// Shared encoding constants for the immediate-instruction encoder and the decode stage.
// Format codes, the NOP word and the error-counter width live here so both ends agree.
package imm_instr_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;
  localparam int          ERR_COUNT_WIDTH = 8;
  localparam logic [ERR_COUNT_WIDTH-1:0] ERR_COUNT_MAX = '1;

endpackage : imm_instr_encoder_pkg

// File: rtl/imm_field_pack.sv
// Combinational RV32 field packer with immediate range check.
// Out-of-range immediates are still packed (truncated); illegal formats yield a NOP.
module imm_field_pack
  import imm_instr_encoder_pkg::*;
(
  input  logic [2:0]  format,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        imm_err
);

  logic fits_12;
  logic fits_13;
  logic fits_21;

  // An immediate is representable when it equals the sign-extension of its low field.
  assign fits_12 = (imm == {{20{imm[11]}}, imm[11:0]});
  assign fits_13 = (imm == {{19{imm[12]}}, imm[12:0]});
  assign fits_21 = (imm == {{11{imm[20]}}, imm[20:0]});

  always_comb begin
    instr   = NOP_INSTR;
    imm_err = 1'b0;
    case (format)
      FMT_R: begin
        instr = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      FMT_I: begin
        instr   = {imm[11:0], rs1, funct3, rd, opcode};
        imm_err = ~fits_12;
      end
      FMT_S: begin
        instr   = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        imm_err = ~fits_12;
      end
      FMT_B: begin
        instr   = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        imm_err = ~fits_13 | imm[0];
      end
      FMT_U: begin
        instr   = {imm[31:12], rd, opcode};
        imm_err = |imm[11:0];
      end
      FMT_J: begin
        instr   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        imm_err = ~fits_21 | imm[0];
      end
      default: begin
        instr   = NOP_INSTR;
        imm_err = 1'b1;
      end
    endcase
  end

endmodule : imm_field_pack

// File: rtl/imm_instr_encoder.sv
// Single-entry handshake stage around imm_field_pack: registers the encoded word,
// tags it with an instruction-memory address and keeps a saturating error total.
//
// state    | meaning
// ---------+------------------------------------------------
// ST_EMPTY | no word held, input always accepted
// ST_FULL  | word held on instruction/addr, awaiting out_ready
module imm_instr_encoder
  import imm_instr_encoder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 format,
  input  logic [6:0]                 opcode,
  input  logic [4:0]                 rd,
  input  logic [4:0]                 rs1,
  input  logic [4:0]                 rs2,
  input  logic [2:0]                 funct3,
  input  logic [6:0]                 funct7,
  input  logic [31:0]                imm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                instruction,
  output logic [ADDR_WIDTH-1:0]      addr,
  output logic                       imm_err,
  output logic [ERR_COUNT_WIDTH-1:0] err_count
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e                state_q;
  state_e                state_d;
  logic                  in_xfer;
  logic                  out_xfer;
  logic [31:0]           pack_instr;
  logic                  pack_err;
  logic [ADDR_WIDTH-1:0] addr_cnt;

  imm_field_pack u_pack (
    .format  (format),
    .opcode  (opcode),
    .rd      (rd),
    .rs1     (rs1),
    .rs2     (rs2),
    .funct3  (funct3),
    .funct7  (funct7),
    .imm     (imm),
    .instr   (pack_instr),
    .imm_err (pack_err)
  );

  // Ready while empty, or when the held word leaves this same cycle.
  assign in_ready  = (state_q == ST_EMPTY) | out_ready;
  assign out_valid = (state_q == ST_FULL);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (in_xfer) state_d = ST_FULL;
      ST_FULL:  if (out_xfer && !in_xfer) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instruction <= '0;
      imm_err     <= 1'b0;
      addr        <= '0;
      addr_cnt    <= '0;
      err_count   <= '0;
    end else if (in_xfer) begin
      instruction <= pack_instr;
      imm_err     <= pack_err;
      addr        <= addr_cnt;
      addr_cnt    <= addr_cnt + 1'b1;
      if (pack_err && (err_count != ERR_COUNT_MAX)) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

endmodule : imm_instr_encoder

// File: tb/tb_imm_instr_encoder.sv
// Directed bench for imm_instr_encoder (ADDR_WIDTH=2 so the address wrap is reachable).
module tb_imm_instr_encoder;
  import imm_instr_encoder_pkg::*;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    format;
  logic [6:0]    opcode;
  logic [4:0]    rd, rs1, rs2;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic [31:0]   imm;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   instruction;
  logic [AW-1:0] addr;
  logic          imm_err;
  logic [ERR_COUNT_WIDTH-1:0] err_count;

  int n_cmp = 0;
  int n_err = 0;

  imm_instr_encoder #(.ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .format      (format),
    .opcode      (opcode),
    .rd          (rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .funct3      (funct3),
    .funct7      (funct7),
    .imm         (imm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .instruction (instruction),
    .addr        (addr),
    .imm_err     (imm_err),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] im);
    format = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
  endtask

  // Decode-stage immediate extension, written from the RV32 instruction formats.
  function automatic logic [31:0] ext_imm(input logic [2:0] f, input logic [31:0] ins);
    case (f)
      FMT_I:   return {{20{ins[31]}}, ins[31:20]};
      FMT_S:   return {{20{ins[31]}}, ins[31:25], ins[11:7]};
      FMT_B:   return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_U:   return {ins[31:12], 12'b0};
      FMT_J:   return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_req(3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0);
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_instr", instruction, 32'h0);
    check("rst_imm_err", 32'(imm_err), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    step(); step();
    reset = 1'b1;
    step();

    // addi x1, x2, -2048
    set_req(FMT_I, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800);
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("i_in_ready", 32'(in_ready), 32'd1);
    check("i_pre_valid", 32'(out_valid), 32'd0);
    step();
    check("i_valid", 32'(out_valid), 32'd1);
    check("i_instr", instruction, 32'h8001_0093);
    check("i_err", 32'(imm_err), 32'd0);
    check("i_addr", 32'(addr), 32'd0);

    // Odd branch offset: flagged but still emitted
    set_req(FMT_B, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0801);
    step();
    check("b_instr", instruction, 32'h0000_00E3);
    check("b_err", 32'(imm_err), 32'd1);
    check("b_err_count", 32'(err_count), 32'd1);
    check("b_addr", 32'(addr), 32'd1);
    in_valid = 1'b0;
    step();
    check("drain_valid", 32'(out_valid), 32'd0);

    // Backpressure: sub x1,x2,x3 held while addi x5,x0,5 waits
    out_ready = 1'b0;
    set_req(FMT_R, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'h0);
    in_valid = 1'b1;
    step();
    check("bp_first", instruction, 32'h4031_00B3);
    set_req(FMT_I, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold_instr", instruction, 32'h4031_00B3);
      check("bp_hold_addr", 32'(addr), 32'd2);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    step();
    check("bp_second", instruction, 32'h0050_0293);
    check("bp_second_addr", 32'(addr), 32'd3);
    in_valid = 1'b0;
    step();
    check("bp_drain", 32'(out_valid), 32'd0);

    // Fresh reset, then five back-to-back U-type transfers wrapping the address
    reset = 1'b0;
    step();
    reset = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_req(FMT_U, 7'h37, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'(i) << 12);
      step();
      check("tp_valid", 32'(out_valid), 32'd1);
      check("tp_addr", 32'(addr), 32'(i % 4));
      check("tp_instr", instruction, (32'(i) << 12) | 32'h0000_0137);
    end

    // Illegal format, then saturate the error counter
    set_req(3'd7, 7'h33, 5'd1, 5'd1, 5'd1, 3'd1, 7'd1, 32'h1234_5678);
    step();
    check("ill_instr", instruction, 32'h0000_0013);
    check("ill_err", 32'(imm_err), 32'd1);
    check("ill_err_count", 32'(err_count), 32'd1);
    for (int i = 2; i <= 300; i++) begin
      step();
      if (i == 254) check("sat_254", 32'(err_count), 32'd254);
      if (i == 255) check("sat_255", 32'(err_count), 32'd255);
    end
    check("sat_300", 32'(err_count), 32'd255);

    // Reset while a word is held
    out_ready = 1'b0;
    step();
    check("mid_valid_pre", 32'(out_valid), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_valid", 32'(out_valid), 32'd0);
    check("mid_addr", 32'(addr), 32'd0);
    check("mid_err_count", 32'(err_count), 32'd0);
    in_valid = 1'b0;
    step();
    reset = 1'b1;
    out_ready = 1'b1;

    // Random legal immediates must survive decode-stage extension
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      logic [31:0] r;
      logic [31:0] im;
      logic [2:0]  f;
      r = $urandom;
      f = 3'($urandom_range(1, 5));
      case (f)
        FMT_I, FMT_S: im = {{20{r[11]}}, r[11:0]};
        FMT_B:        im = {{19{r[12]}}, r[12:1], 1'b0};
        FMT_U:        im = {r[31:12], 12'b0};
        default:      im = {{11{r[20]}}, r[20:1], 1'b0};
      endcase
      set_req(f, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
              3'($urandom), 7'($urandom), im);
      step();
      check("rt_addr", 32'(addr), 32'(k % 4));
      check("rt_err", 32'(imm_err), 32'd0);
      check("rt_imm", ext_imm(f, instruction), im);
    end
    in_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_imm_instr_encoder
